sdram_burst_write: RTL and testbench



---
 rtl/sdram_burst_write_if.sv | 30 +++
 rtl/sdram_burst_write.sv | 226 ++++++++++++++++++++++
 tb/tb_sdram_burst_write.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_burst_write_if.sv
// Request/grant bundle between the SDRAM arbiter and the burst write engine.
// Latency: none, wires only.
// Backpressure: obusy high means ireq is ignored, ienb low releases the DRAM pins.
interface sdram_burst_write_if #(
    parameter int DB_WIDTH  = 16,
    parameter int BURST_LEN = 8,
    parameter int ROW_W     = 13,
    parameter int COL_W     = 10,
    parameter int BANK_W    = 2
);
    logic                              ireq;
    logic                              ienb;
    logic [ROW_W-1:0]                  irow;
    logic [COL_W-1:0]                  icolumn;
    logic [BANK_W-1:0]                 ibank;
    logic [BURST_LEN*DB_WIDTH-1:0]     idata;
    logic [BURST_LEN*DB_WIDTH/8-1:0]   ibyte_mask;
    logic                              obusy;
    logic                              ofin;

    modport master (
        output ireq, ienb, irow, icolumn, ibank, idata, ibyte_mask,
        input  obusy, ofin
    );

    modport slave (
        input  ireq, ienb, irow, icolumn, ibank, idata, ibyte_mask,
        output obusy, ofin
    );
endinterface

// File: rtl/sdram_burst_write.sv
// Single-bank SDRAM write engine: ACTIVATE, tRCD, masked burst, tWR, precharge, done pulse.
// Latency: T_RCD+BURST_LEN+T_WR+T_RP edges from acceptance to ofin; all pins registered.
// Backpressure: requests are ignored while obusy; pins tri-state whenever ienb is low.
module sdram_burst_write #(
    parameter int DB_WIDTH       = 16,
    parameter int BURST_LEN      = 8,
    parameter int ROW_W          = 13,
    parameter int COL_W          = 10,
    parameter int BANK_W         = 2,
    parameter int T_RCD          = 2,
    parameter int T_WR           = 2,
    parameter int T_RP           = 2,
    parameter int AUTO_PRECHARGE = 1
) (
    input  logic                     iclk,
    input  logic                     ireset_n,
    sdram_burst_write_if.slave       bus,
    output wire                      DRAM_CLK,
    output wire                      DRAM_CKE,
    output wire  [ROW_W-1:0]         DRAM_ADDR,
    output wire  [BANK_W-1:0]        DRAM_BA,
    output wire                      DRAM_CS_N,
    output wire                      DRAM_RAS_N,
    output wire                      DRAM_CAS_N,
    output wire                      DRAM_WE_N,
    output wire  [DB_WIDTH/8-1:0]    DRAM_DQM,
    output wire  [DB_WIDTH-1:0]      DRAM_DQ
);

    localparam int BYTES   = DB_WIDTH / 8;
    localparam int DW      = BURST_LEN * DB_WIDTH;
    localparam int MW      = BURST_LEN * BYTES;
    localparam int M1      = (T_RCD > T_WR) ? T_RCD : T_WR;
    localparam int M2      = (T_RP > BURST_LEN) ? T_RP : BURST_LEN;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;

    localparam logic [ROW_W-1:0] A10_BIT = ROW_W'(1) << 10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_RCD,
        S_WR,
        S_BURST,
        S_TWR,
        S_PRE,
        S_TRP,
        S_FIN
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [COL_W-1:0]    col_q;
    logic [BANK_W-1:0]   bank_q;
    logic [DW-1:0]       data_q;
    logic [MW-1:0]       mask_q;

    logic [3:0]          cmd_q;
    logic [ROW_W-1:0]    addr_q;
    logic [BANK_W-1:0]   ba_q;
    logic [BYTES-1:0]    dqm_q;
    logic [DB_WIDTH-1:0] dq_q;
    logic                busy_q;
    logic                fin_q;

    logic                start_wr;
    logic                more_beats;
    logic                last_beat;
    logic [ROW_W-1:0]    wr_addr;
    logic [DB_WIDTH-1:0] beat_dat;
    logic [BYTES-1:0]    beat_msk;

    // Beats are consumed from the top of the latched burst, most-significant first.
    assign beat_dat = data_q[DW-1 -: DB_WIDTH];
    assign beat_msk = mask_q[MW-1 -: BYTES];
    assign wr_addr  = ROW_W'(col_q) | ((AUTO_PRECHARGE != 0) ? A10_BIT : '0);

    always_comb begin
        start_wr   = 1'b0;
        more_beats = 1'b0;
        last_beat  = 1'b0;
        case (state)
            S_ACT:   start_wr = (T_RCD == 1);
            S_RCD:   start_wr = (cnt == CNT_W'(1));
            S_WR: begin
                more_beats = (BURST_LEN > 1);
                last_beat  = (BURST_LEN == 1);
            end
            S_BURST: begin
                more_beats = (cnt != CNT_W'(1));
                last_beat  = (cnt == CNT_W'(1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            col_q  <= '0;
            bank_q <= '0;
            data_q <= '0;
            mask_q <= '0;
            cmd_q  <= CMD_NOP;
            addr_q <= '0;
            ba_q   <= '0;
            dqm_q  <= '1;
            dq_q   <= '0;
            busy_q <= 1'b0;
            fin_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ireq) begin
                        col_q  <= bus.icolumn;
                        bank_q <= bus.ibank;
                        data_q <= bus.idata;
                        mask_q <= bus.ibyte_mask;
                        busy_q <= 1'b1;
                        state  <= S_ACT;
                        cmd_q  <= CMD_ACT;
                        addr_q <= bus.irow;
                        ba_q   <= bus.ibank;
                    end
                end
                S_ACT, S_RCD: begin
                    if (start_wr) begin
                        state  <= S_WR;
                        cmd_q  <= CMD_WRITE;
                        addr_q <= wr_addr;
                        ba_q   <= bank_q;
                        cnt    <= CNT_W'(BURST_LEN - 1);
                    end else if (state == S_ACT) begin
                        state <= S_RCD;
                        cmd_q <= CMD_NOP;
                        cnt   <= CNT_W'(T_RCD - 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_WR, S_BURST: begin
                    cmd_q <= CMD_NOP;
                    if (last_beat) begin
                        state <= S_TWR;
                        cnt   <= CNT_W'(T_WR);
                    end else begin
                        state <= S_BURST;
                        if (state == S_BURST) cnt <= cnt - CNT_W'(1);
                    end
                end
                S_TWR: begin
                    if (cnt == CNT_W'(1)) begin
                        if (AUTO_PRECHARGE != 0) begin
                            state <= S_TRP;
                            cnt   <= CNT_W'(T_RP);
                        end else begin
                            state  <= S_PRE;
                            cmd_q  <= CMD_PRE;
                            addr_q <= '0;
                            ba_q   <= bank_q;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_PRE: begin
                    // The PRECHARGE cycle itself counts toward tRP.
                    cmd_q <= CMD_NOP;
                    if (T_RP == 1) begin
                        state <= S_FIN;
                        fin_q <= 1'b1;
                    end else begin
                        state <= S_TRP;
                        cnt   <= CNT_W'(T_RP - 1);
                    end
                end
                S_TRP: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= S_FIN;
                        fin_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_FIN: begin
                    state  <= S_IDLE;
                    fin_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase

            if (start_wr || more_beats) begin
                dq_q   <= beat_dat;
                dqm_q  <= beat_msk;
                data_q <= data_q << DB_WIDTH;
                mask_q <= mask_q << BYTES;
            end else if (last_beat) begin
                dqm_q <= '1;
            end
        end
    end

    assign bus.obusy  = busy_q;
    assign bus.ofin   = fin_q;

    assign DRAM_CLK   = bus.ienb ? ~iclk     : 1'bz;
    assign DRAM_CKE   = bus.ienb ? 1'b1      : 1'bz;
    assign DRAM_CS_N  = bus.ienb ? cmd_q[3]  : 1'bz;
    assign DRAM_RAS_N = bus.ienb ? cmd_q[2]  : 1'bz;
    assign DRAM_CAS_N = bus.ienb ? cmd_q[1]  : 1'bz;
    assign DRAM_WE_N  = bus.ienb ? cmd_q[0]  : 1'bz;
    assign DRAM_ADDR  = bus.ienb ? addr_q    : {ROW_W{1'bz}};
    assign DRAM_BA    = bus.ienb ? ba_q      : {BANK_W{1'bz}};
    assign DRAM_DQM   = bus.ienb ? dqm_q     : {BYTES{1'bz}};
    assign DRAM_DQ    = bus.ienb ? dq_q      : {DB_WIDTH{1'bz}};

endmodule

// File: tb/tb_sdram_burst_write.sv
// Bench for sdram_burst_write: two configurations driven in parallel, each checked
// every cycle against a per-transaction expected pin trace built from the command rules.
module tb_sdram_burst_write;

    localparam int P0_RCD = 2, P0_WR = 2, P0_RP = 2, P0_AP = 1;
    localparam int P1_RCD = 3, P1_WR = 3, P1_RP = 2, P1_AP = 0;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  ba;
        logic [1:0]  dqm;
        logic [15:0] dq;
        logic        busy;
        logic        fin;
    } entry_t;

    typedef struct packed {
        logic        dclk;
        logic        cke;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  ba;
        logic [1:0]  dqm;
        logic [15:0] dq;
        logic        busy;
        logic        fin;
    } pins_t;

    localparam entry_t RESET_E = '{cmd: 4'b0111, addr: 13'h0, ba: 2'h0, dqm: 2'b11,
                                   dq: 16'h0, busy: 1'b0, fin: 1'b0};

    logic         iclk = 1'b0;
    logic         ireset_n = 1'b1;
    logic         ireq = 1'b0;
    logic         ienb = 1'b1;
    logic [12:0]  irow = '0;
    logic [9:0]   icolumn = '0;
    logic [1:0]   ibank = '0;
    logic [127:0] idata = '0;
    logic [15:0]  imask = '0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    entry_t q [2][$];
    entry_t last [2];

    sdram_burst_write_if bus0 ();
    sdram_burst_write_if bus1 ();

    assign bus0.ireq = ireq;     assign bus1.ireq = ireq;
    assign bus0.ienb = ienb;     assign bus1.ienb = ienb;
    assign bus0.irow = irow;     assign bus1.irow = irow;
    assign bus0.icolumn = icolumn; assign bus1.icolumn = icolumn;
    assign bus0.ibank = ibank;   assign bus1.ibank = ibank;
    assign bus0.idata = idata;   assign bus1.idata = idata;
    assign bus0.ibyte_mask = imask; assign bus1.ibyte_mask = imask;

    wire        dclk0, cke0, cs0, ras0, cas0, we0;
    wire [12:0] addr0;
    wire [1:0]  ba0, dqm0;
    wire [15:0] dq0;
    wire        dclk1, cke1, cs1, ras1, cas1, we1;
    wire [12:0] addr1;
    wire [1:0]  ba1, dqm1;
    wire [15:0] dq1;

    sdram_burst_write u_dut0 (
        .iclk(iclk), .ireset_n(ireset_n), .bus(bus0.slave),
        .DRAM_CLK(dclk0), .DRAM_CKE(cke0), .DRAM_ADDR(addr0), .DRAM_BA(ba0),
        .DRAM_CS_N(cs0), .DRAM_RAS_N(ras0), .DRAM_CAS_N(cas0), .DRAM_WE_N(we0),
        .DRAM_DQM(dqm0), .DRAM_DQ(dq0)
    );

    sdram_burst_write #(
        .T_RCD(P1_RCD), .T_WR(P1_WR), .T_RP(P1_RP), .AUTO_PRECHARGE(P1_AP)
    ) u_dut1 (
        .iclk(iclk), .ireset_n(ireset_n), .bus(bus1.slave),
        .DRAM_CLK(dclk1), .DRAM_CKE(cke1), .DRAM_ADDR(addr1), .DRAM_BA(ba1),
        .DRAM_CS_N(cs1), .DRAM_RAS_N(ras1), .DRAM_CAS_N(cas1), .DRAM_WE_N(we1),
        .DRAM_DQM(dqm1), .DRAM_DQ(dq1)
    );

    pins_t obs0, obs1;
    assign obs0 = {dclk0, cke0, cs0, ras0, cas0, we0, addr0, ba0, dqm0, dq0, bus0.obusy, bus0.ofin};
    assign obs1 = {dclk1, cke1, cs1, ras1, cas1, we1, addr1, ba1, dqm1, dq1, bus1.obusy, bus1.ofin};

    always #5 iclk = ~iclk;

    function automatic void model_reset(input int d);
        q[d].delete();
        last[d] = RESET_E;
    endfunction

    // Whole expected pin trace for one accepted request, one entry per cycle.
    function automatic void push_trace(input int d);
        int t_rcd, t_wr, t_rp, ap;
        entry_t e;
        t_rcd = (d == 0) ? P0_RCD : P1_RCD;
        t_wr  = (d == 0) ? P0_WR  : P1_WR;
        t_rp  = (d == 0) ? P0_RP  : P1_RP;
        ap    = (d == 0) ? P0_AP  : P1_AP;
        e = last[d];
        e.busy = 1'b1; e.fin = 1'b0;
        e.cmd = C_ACT; e.addr = irow; e.ba = ibank; e.dqm = 2'b11;
        q[d].push_back(e);
        e.cmd = C_NOP;
        for (int i = 1; i < t_rcd; i++) q[d].push_back(e);
        for (int k = 0; k < 8; k++) begin
            e.cmd = (k == 0) ? C_WR : C_NOP;
            if (k == 0) e.addr = 13'(icolumn) | ((ap != 0) ? 13'h400 : 13'h000);
            e.dq  = idata[(8 - k) * 16 - 1 -: 16];
            e.dqm = imask[(8 - k) * 2 - 1 -: 2];
            q[d].push_back(e);
        end
        e.cmd = C_NOP; e.dqm = 2'b11;
        for (int i = 0; i < t_wr; i++) q[d].push_back(e);
        if (ap == 0) begin
            e.cmd = C_PRE; e.addr = '0;
            q[d].push_back(e);
            e.cmd = C_NOP;
            for (int i = 1; i < t_rp; i++) q[d].push_back(e);
        end else begin
            for (int i = 0; i < t_rp; i++) q[d].push_back(e);
        end
        e.fin = 1'b1;
        q[d].push_back(e);
    endfunction

    function automatic void model_edge(input int d);
        if (!ireset_n) begin
            model_reset(d);
            return;
        end
        if (!last[d].busy && ireq) push_trace(d);
        if (q[d].size() > 0) begin
            last[d] = q[d].pop_front();
        end else begin
            last[d].cmd = C_NOP; last[d].dqm = 2'b11;
            last[d].busy = 1'b0; last[d].fin = 1'b0;
        end
    endfunction

    function automatic pins_t exp_pins(input entry_t e);
        pins_t p;
        p.busy = e.busy;
        p.fin  = e.fin;
        if (ienb) begin
            p.dclk = ~iclk; p.cke = 1'b1; p.cmd = e.cmd; p.addr = e.addr;
            p.ba = e.ba; p.dqm = e.dqm; p.dq = e.dq;
        end else begin
            p.dclk = 1'bz; p.cke = 1'bz; p.cmd = 4'bzzzz; p.addr = {13{1'bz}};
            p.ba = 2'bzz; p.dqm = 2'bzz; p.dq = {16{1'bz}};
        end
        return p;
    endfunction

    task automatic tick();
        @(posedge iclk);
        model_edge(0);
        model_edge(1);
        cyc++;
        #1;
    endtask

    task automatic rand_inputs();
        irow    = 13'($urandom);
        icolumn = 10'($urandom);
        ibank   = 2'($urandom);
        idata   = {$urandom, $urandom, $urandom, $urandom};
        imask   = 16'($urandom);
    endtask

    task automatic test_reset();
        #2 ireset_n = 1'b0;
        model_reset(0); model_reset(1);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            else #1;
            for (int d = 0; d < 2; d++) begin
                pins_t o, x;
                o = (d == 0) ? obs0 : obs1;
                x = exp_pins(last[d]);
                n_chk++;
                if (o !== x) begin
                    n_fail++;
                    $display("FAIL reset dut%0d cyc %0d: got %h expected %h", d, cyc, o, x);
                end
            end
        end
        ireset_n = 1'b1;
        tick();
        n_chk++;
        if (obs0.cmd !== C_NOP || obs0.dqm !== 2'b11 || obs0.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got cmd %b dqm %b busy %b expected 0111 11 0",
                     obs0.cmd, obs0.dqm, obs0.busy);
        end
    endtask

    task automatic test_basic();
        int acc;
        int fin_at [2];
        irow = 13'h1A5; icolumn = 10'h020; ibank = 2'd2;
        idata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        imask = 16'h0000;
        ireq = 1'b1;
        tick();
        acc = cyc;
        fin_at[0] = -1; fin_at[1] = -1;
        ireq = 1'b0;
        for (int c = 0; c < 22; c++) begin
            if (c > 0) tick();
            for (int d = 0; d < 2; d++) begin
                pins_t o, x;
                o = (d == 0) ? obs0 : obs1;
                x = exp_pins(last[d]);
                n_chk++;
                if (o !== x) begin
                    n_fail++;
                    $display("FAIL basic dut%0d cyc %0d: got %h expected %h", d, cyc, o, x);
                end
                if (o.fin === 1'b1 && fin_at[d] < 0) fin_at[d] = cyc;
            end
        end
        n_chk++;
        if (fin_at[0] - acc != P0_RCD + 8 + P0_WR + P0_RP) begin
            n_fail++;
            $display("FAIL latency dut0: got %0d expected %0d", fin_at[0] - acc, P0_RCD + 8 + P0_WR + P0_RP);
        end
        n_chk++;
        if (fin_at[1] - acc != P1_RCD + 8 + P1_WR + P1_RP) begin
            n_fail++;
            $display("FAIL latency dut1: got %0d expected %0d", fin_at[1] - acc, P1_RCD + 8 + P1_WR + P1_RP);
        end
    endtask

    task automatic test_mask();
        int acc;
        rand_inputs();
        imask = 16'h0009;
        ireq = 1'b1;
        tick();
        acc = cyc;
        ireq = 1'b0;
        for (int c = 0; c < 22; c++) begin
            if (c > 0) tick();
            for (int d = 0; d < 2; d++) begin
                pins_t o, x;
                o = (d == 0) ? obs0 : obs1;
                x = exp_pins(last[d]);
                n_chk++;
                if (o !== x) begin
                    n_fail++;
                    $display("FAIL mask dut%0d cyc %0d: got %h expected %h", d, cyc, o, x);
                end
            end
            if (cyc - acc >= P0_RCD && cyc - acc < P0_RCD + 8) begin
                logic [1:0] want;
                want = (cyc - acc == P0_RCD + 6) ? 2'b10 :
                       (cyc - acc == P0_RCD + 7) ? 2'b01 : 2'b00;
                n_chk++;
                if (obs0.dqm !== want) begin
                    n_fail++;
                    $display("FAIL mask_beat%0d: got %b expected %b", cyc - acc - P0_RCD, obs0.dqm, want);
                end
            end
        end
    endtask

    task automatic test_toggle();
        for (int t = 0; t < 4; t++) begin
            rand_inputs();
            ireq = 1'b1;
            tick();
            for (int c = 0; c < 22; c++) begin
                ireq = (c < 12) ? 1'($urandom) : 1'b0;
                rand_inputs();
                tick();
                for (int d = 0; d < 2; d++) begin
                    pins_t o, x;
                    o = (d == 0) ? obs0 : obs1;
                    x = exp_pins(last[d]);
                    n_chk++;
                    if (o !== x) begin
                        n_fail++;
                        $display("FAIL toggle dut%0d cyc %0d: got %h expected %h", d, cyc, o, x);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int last_fin;
        int n_fin;
        last_fin = -1;
        n_fin = 0;
        ireq = 1'b1;
        for (int c = 0; c < 84; c++) begin
            if (c == 60) ireq = 1'b0;
            rand_inputs();
            tick();
            for (int d = 0; d < 2; d++) begin
                pins_t o, x;
                o = (d == 0) ? obs0 : obs1;
                x = exp_pins(last[d]);
                n_chk++;
                if (o !== x) begin
                    n_fail++;
                    $display("FAIL b2b dut%0d cyc %0d: got %h expected %h", d, cyc, o, x);
                end
            end
            if (obs0.cmd === C_ACT && last_fin >= 0) begin
                n_chk++;
                if (cyc - last_fin != 2) begin
                    n_fail++;
                    $display("FAIL b2b_gap: got %0d expected 2", cyc - last_fin);
                end
            end
            if (obs0.fin === 1'b1) begin
                last_fin = cyc;
                n_fin++;
            end
        end
        n_chk++;
        if (n_fin != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 4", n_fin);
        end
    endtask

    task automatic test_reset_mid();
        rand_inputs();
        ireq = 1'b1;
        tick();
        ireq = 1'b0;
        repeat (P0_RCD + 4) tick();
        #2 ireset_n = 1'b0;
        model_reset(0); model_reset(1);
        #1;
        n_chk++;
        if (obs0.cmd !== C_NOP || obs0.dqm !== 2'b11 || obs0.busy !== 1'b0 || obs1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got cmd %b dqm %b busy %b/%b expected 0111 11 0/0",
                     obs0.cmd, obs0.dqm, obs0.busy, obs1.busy);
        end
        tick();
        ireset_n = 1'b1;
        rand_inputs();
        ireq = 1'b1;
        for (int c = 0; c < 22; c++) begin
            tick();
            ireq = 1'b0;
            for (int d = 0; d < 2; d++) begin
                pins_t o, x;
                o = (d == 0) ? obs0 : obs1;
                x = exp_pins(last[d]);
                n_chk++;
                if (o !== x) begin
                    n_fail++;
                    $display("FAIL after_reset dut%0d cyc %0d: got %h expected %h", d, cyc, o, x);
                end
            end
        end
    endtask

    task automatic test_ienb();
        int n_fin [2];
        n_fin[0] = 0; n_fin[1] = 0;
        ienb = 1'b0;
        rand_inputs();
        ireq = 1'b1;
        for (int c = 0; c < 22; c++) begin
            tick();
            ireq = 1'b0;
            for (int d = 0; d < 2; d++) begin
                pins_t o, x;
                o = (d == 0) ? obs0 : obs1;
                x = exp_pins(last[d]);
                n_chk++;
                if (o !== x) begin
                    n_fail++;
                    $display("FAIL ienb dut%0d cyc %0d: got %h expected %h", d, cyc, o, x);
                end
                if (o.fin === 1'b1) n_fin[d]++;
            end
        end
        n_chk++;
        if (n_fin[0] != 1 || n_fin[1] != 1) begin
            n_fail++;
            $display("FAIL ienb_fin: got %0d/%0d expected 1/1", n_fin[0], n_fin[1]);
        end
        ienb = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_toggle();
        test_back_to_back();
        test_reset_mid();
        test_ienb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
